// File: rtl/dcache_port_scheduler.sv
// dcache_port_scheduler: buffers one request per lane and issues them onto a dual-ported dcache, serializing overlaps.
// Optional macro DCACHE_SCHED_STATS_EN adds a saturating conflictCount output.
module dcache_port_scheduler #(
    parameter int addrSize = 32,
    parameter int dataSize = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reqValid1,
    input  logic                reqValid2,
    output logic                reqReady1,
    output logic                reqReady2,
    input  logic                reqStore1,
    input  logic                reqStore2,
    input  logic [addrSize-1:0] reqAddr1,
    input  logic [addrSize-1:0] reqAddr2,
    input  logic [dataSize-1:0] reqWdata1,
    input  logic [dataSize-1:0] reqWdata2,
    output logic                rspValid1,
    output logic                rspValid2,
    output logic [dataSize-1:0] rspData1,
    output logic [dataSize-1:0] rspData2,
    output logic                cacheWe1,
    output logic                cacheWe2,
    output logic [addrSize-1:0] cacheAddr1,
    output logic [addrSize-1:0] cacheAddr2,
    output logic [dataSize-1:0] cacheWdata1,
    output logic [dataSize-1:0] cacheWdata2,
    input  logic [dataSize-1:0] cacheRdata1,
    input  logic [dataSize-1:0] cacheRdata2
`ifdef DCACHE_SCHED_STATS_EN
    ,
    output logic [15:0]         conflictCount
`endif
);
    typedef enum logic {DUAL, SPLIT} state_e;
    state_e state_q;
    logic [1:0] req_valid, req_store, accept, ready, issue;
    logic [1:0] held_valid_q, held_valid_d, held_store_q, held_store_d, rsp_valid_q, rsp_valid_d;
    logic [addrSize-1:0] req_addr [2];
    logic [addrSize-1:0] held_addr_q [2];
    logic [addrSize-1:0] held_addr_d [2];
    logic [dataSize-1:0] req_wdata [2];
    logic [dataSize-1:0] held_wdata_q [2];
    logic [dataSize-1:0] held_wdata_d [2];
    logic [dataSize-1:0] cache_rdata [2];
    logic [dataSize-1:0] rsp_data_q [2];
    logic [dataSize-1:0] rsp_data_d [2];
    logic [addrSize-1:0] diff_fwd, diff_bwd;
    logic overlap, conflict;

    assign req_valid = {reqValid2, reqValid1};
    assign req_store = {reqStore2, reqStore1};
    assign req_addr[0] = reqAddr1;
    assign req_addr[1] = reqAddr2;
    assign req_wdata[0] = reqWdata1;
    assign req_wdata[1] = reqWdata2;
    assign cache_rdata[0] = cacheRdata1;
    assign cache_rdata[1] = cacheRdata2;

    // Words span addr..addr-3, so they overlap when the modular distance is within 3 either way.
    assign diff_fwd = held_addr_q[0] - held_addr_q[1];
    assign diff_bwd = held_addr_q[1] - held_addr_q[0];
    assign overlap = (diff_fwd < addrSize'(4)) || (diff_bwd < addrSize'(4));
    assign conflict = (&held_valid_q) & overlap & (|held_store_q);

    assign issue[0] = held_valid_q[0] & (state_q == DUAL);
    assign issue[1] = held_valid_q[1] & ((state_q == SPLIT) | ~conflict);
    assign ready = ~held_valid_q | issue;
    assign accept = req_valid & ready;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            held_valid_d[i] = accept[i] | (held_valid_q[i] & ~issue[i]);
            held_store_d[i] = accept[i] ? req_store[i] : held_store_q[i];
            held_addr_d[i] = accept[i] ? req_addr[i] : held_addr_q[i];
            held_wdata_d[i] = accept[i] ? req_wdata[i] : held_wdata_q[i];
            rsp_valid_d[i] = issue[i] & ~held_store_q[i];
            rsp_data_d[i] = rsp_valid_d[i] ? cache_rdata[i] : rsp_data_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DUAL;
            held_valid_q <= '0;
            held_store_q <= '0;
            held_addr_q <= '{default: '0};
            held_wdata_q <= '{default: '0};
            rsp_valid_q <= '0;
            rsp_data_q <= '{default: '0};
        end else begin
            state_q <= (state_q == DUAL && conflict) ? SPLIT : DUAL;
            held_valid_q <= held_valid_d;
            held_store_q <= held_store_d;
            held_addr_q <= held_addr_d;
            held_wdata_q <= held_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q <= rsp_data_d;
        end
    end

`ifdef DCACHE_SCHED_STATS_EN
    logic [15:0] count_q, count_d;
    assign count_d = (state_q == DUAL && conflict && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else count_q <= count_d;
    end
    assign conflictCount = count_q;
`endif

    assign reqReady1 = ready[0];
    assign reqReady2 = ready[1];
    assign rspValid1 = rsp_valid_q[0];
    assign rspValid2 = rsp_valid_q[1];
    assign rspData1 = rsp_data_q[0];
    assign rspData2 = rsp_data_q[1];
    assign cacheWe1 = issue[0] & held_store_q[0];
    assign cacheWe2 = issue[1] & held_store_q[1];
    assign cacheAddr1 = held_addr_q[0];
    assign cacheAddr2 = held_addr_q[1];
    assign cacheWdata1 = held_wdata_q[0];
    assign cacheWdata2 = held_wdata_q[1];
endmodule

// File: tb/tb_dcache_port_scheduler.sv
// tb_dcache_port_scheduler: directed bench with a byte-addressed cache model (falling-edge writes, combinational reads).
module tb_dcache_port_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    logic reqValid1, reqValid2, reqReady1, reqReady2, reqStore1, reqStore2;
    logic [31:0] reqAddr1, reqAddr2, reqWdata1, reqWdata2;
    logic rspValid1, rspValid2;
    logic [31:0] rspData1, rspData2;
    logic cacheWe1, cacheWe2;
    logic [31:0] cacheAddr1, cacheAddr2, cacheWdata1, cacheWdata2, cacheRdata1, cacheRdata2;
`ifdef DCACHE_SCHED_STATS_EN
    logic [15:0] conflictCount;
`endif
    int checks = 0;
    int failures = 0;
    logic [7:0] mem [0:4095];

    always #5 clk = ~clk;

    dcache_port_scheduler #(.addrSize(32), .dataSize(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid1(reqValid1), .reqValid2(reqValid2),
        .reqReady1(reqReady1), .reqReady2(reqReady2),
        .reqStore1(reqStore1), .reqStore2(reqStore2),
        .reqAddr1(reqAddr1), .reqAddr2(reqAddr2),
        .reqWdata1(reqWdata1), .reqWdata2(reqWdata2),
        .rspValid1(rspValid1), .rspValid2(rspValid2),
        .rspData1(rspData1), .rspData2(rspData2),
        .cacheWe1(cacheWe1), .cacheWe2(cacheWe2),
        .cacheAddr1(cacheAddr1), .cacheAddr2(cacheAddr2),
        .cacheWdata1(cacheWdata1), .cacheWdata2(cacheWdata2),
        .cacheRdata1(cacheRdata1), .cacheRdata2(cacheRdata2)
`ifdef DCACHE_SCHED_STATS_EN
        , .conflictCount(conflictCount)
`endif
    );

    // Word at a occupies bytes a (MSB) down to a-3; model keeps the low 12 address bits.
    function automatic logic [31:0] rd(input logic [31:0] a);
        return {mem[a[11:0]], mem[12'(a - 32'd1)], mem[12'(a - 32'd2)], mem[12'(a - 32'd3)]};
    endfunction

    assign cacheRdata1 = rd(cacheAddr1);
    assign cacheRdata2 = rd(cacheAddr2);

    always @(negedge clk) begin
        if (cacheWe1) for (int k = 0; k < 4; k++) mem[12'(cacheAddr1 - 32'(k))] <= cacheWdata1[8*(3-k) +: 8];
        if (cacheWe2) for (int m = 0; m < 4; m++) mem[12'(cacheAddr2 - 32'(m))] <= cacheWdata2[8*(3-m) +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic count_is(input string tag, input logic [15:0] exp);
`ifdef DCACHE_SCHED_STATS_EN
        chk(tag, 32'(conflictCount), 32'(exp));
`else
        if (tag == "" && exp == 16'd0) $display("no stats");
`endif
    endtask

    task automatic idle();
        reqValid1 = 1'b0;
        reqValid2 = 1'b0;
    endtask

    task automatic drive1(input logic st, input logic [31:0] a, input logic [31:0] w);
        reqValid1 = 1'b1; reqStore1 = st; reqAddr1 = a; reqWdata1 = w;
    endtask

    task automatic drive2(input logic st, input logic [31:0] a, input logic [31:0] w);
        reqValid2 = 1'b1; reqStore2 = st; reqAddr2 = a; reqWdata2 = w;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        reqStore1 = 1'b0; reqStore2 = 1'b0;
        reqAddr1 = '0; reqAddr2 = '0; reqWdata1 = '0; reqWdata2 = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready1", 32'(reqReady1), 32'd1);
        chk("rst_ready2", 32'(reqReady2), 32'd1);
        chk("rst_rspv1", 32'(rspValid1), 32'd0);
        chk("rst_rspv2", 32'(rspValid2), 32'd0);
        chk("rst_rspd1", rspData1, 32'd0);
        chk("rst_rspd2", rspData2, 32'd0);
        chk("rst_we1", 32'(cacheWe1), 32'd0);
        chk("rst_we2", 32'(cacheWe2), 32'd0);
        count_is("rst_count", 16'd0);
        rst_n = 1'b1;

        drive1(1'b1, 32'h103, 32'h11223344);
        drive2(1'b1, 32'h203, 32'h55667788);
        cyc(); idle();
        chk("t1_we1", 32'(cacheWe1), 32'd1);
        chk("t1_we2", 32'(cacheWe2), 32'd1);
        chk("t1_addr1", cacheAddr1, 32'h103);
        cyc();
        chk("t1_mem1", rd(32'h103), 32'h11223344);
        chk("t1_mem2", rd(32'h203), 32'h55667788);
        count_is("t1_count", 16'd0);

        drive1(1'b1, 32'h107, 32'hAABBCCDD);
        drive2(1'b0, 32'h105, 32'h0);
        cyc(); idle();
        chk("t2_we1", 32'(cacheWe1), 32'd1);
        chk("t2_we2_stall", 32'(cacheWe2), 32'd0);
        chk("t2_ready2_stall", 32'(reqReady2), 32'd0);
        chk("t2_ready1", 32'(reqReady1), 32'd1);
        cyc();
        chk("t2_split_we1", 32'(cacheWe1), 32'd0);
        chk("t2_split_addr2", cacheAddr2, 32'h105);
        chk("t2_split_ready2", 32'(reqReady2), 32'd1);
        chk("t2_rspv2_early", 32'(rspValid2), 32'd0);
        cyc();
        chk("t2_rspv2", 32'(rspValid2), 32'd1);
        chk("t2_rspd2", rspData2, 32'hCCDD1122);
        chk("t2_rspv1", 32'(rspValid1), 32'd0);
        count_is("t2_count", 16'd1);

        drive1(1'b1, 32'h40, 32'h5AA53CC3);
        cyc(); idle();
        chk("t3_store_we1", 32'(cacheWe1), 32'd1);
        chk("t3_store_we2", 32'(cacheWe2), 32'd0);
        drive1(1'b0, 32'h40, 32'h0);
        drive2(1'b0, 32'h40, 32'h0);
        cyc(); idle();
        chk("t3_we1", 32'(cacheWe1), 32'd0);
        chk("t3_rspv1_early", 32'(rspValid1), 32'd0);
        cyc();
        chk("t3_rspv1", 32'(rspValid1), 32'd1);
        chk("t3_rspv2", 32'(rspValid2), 32'd1);
        chk("t3_rspd1", rspData1, 32'h5AA53CC3);
        chk("t3_rspd2", rspData2, 32'h5AA53CC3);

        drive1(1'b1, 32'hFFFFFFFF, 32'h01020304);
        drive2(1'b1, 32'h00000001, 32'hA1B2C3D4);
        cyc(); idle();
        chk("t4_we1", 32'(cacheWe1), 32'd1);
        chk("t4_we2_stall", 32'(cacheWe2), 32'd0);
        cyc();
        chk("t4_split_we1", 32'(cacheWe1), 32'd0);
        chk("t4_split_we2", 32'(cacheWe2), 32'd1);
        cyc();
        chk("t4_mem_hi", rd(32'hFFFFFFFF), 32'hC3D40304);
        chk("t4_mem_lo", rd(32'h00000001), 32'hA1B2C3D4);
        count_is("t4_count", 16'd2);

        drive1(1'b1, 32'h200, 32'h99887766);
        drive2(1'b0, 32'h201, 32'h0);
        cyc(); idle();
        chk("t5_we1", 32'(cacheWe1), 32'd1);
        chk("t5_ready1", 32'(reqReady1), 32'd1);
        drive1(1'b0, 32'h103, 32'h0);
        cyc(); idle();
        chk("t5_split_we1", 32'(cacheWe1), 32'd0);
        chk("t5_split_ready1", 32'(reqReady1), 32'd0);
        chk("t5_split_addr2", cacheAddr2, 32'h201);
        chk("t5_split_rspv1", 32'(rspValid1), 32'd0);
        cyc();
        chk("t5_rspv2", 32'(rspValid2), 32'd1);
        chk("t5_rspd2", rspData2, 32'h77998877);
        chk("t5_rspv1_early", 32'(rspValid1), 32'd0);
        chk("t5_ready1", 32'(reqReady1), 32'd1);
        cyc();
        chk("t5_rspv1", 32'(rspValid1), 32'd1);
        chk("t5_rspd1", rspData1, 32'h11223344);
        chk("t5_rspv2_off", 32'(rspValid2), 32'd0);
        count_is("t5_count", 16'd3);

        drive1(1'b1, 32'h300, 32'h12345678);
        drive2(1'b1, 32'h302, 32'hDEADBEEF);
        cyc(); idle();
        chk("t6_we1", 32'(cacheWe1), 32'd1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we2", 32'(cacheWe2), 32'd0);
        chk("t6_rst_we1", 32'(cacheWe1), 32'd0);
        chk("t6_rst_ready1", 32'(reqReady1), 32'd1);
        chk("t6_rst_ready2", 32'(reqReady2), 32'd1);
        chk("t6_rst_rspd1", rspData1, 32'd0);
        chk("t6_rst_rspd2", rspData2, 32'd0);
        chk("t6_rst_rspv2", 32'(rspValid2), 32'd0);
        count_is("t6_rst_count", 16'd0);
        @(negedge clk);
        #1;
        chk("t6_mem_kept", rd(32'h300), 32'h12345678);
        cyc();
        rst_n = 1'b1;
        drive2(1'b0, 32'h300, 32'h0);
        cyc(); idle();
        chk("t6_post_addr2", cacheAddr2, 32'h300);
        chk("t6_post_we2", 32'(cacheWe2), 32'd0);
        chk("t6_post_rspv2_early", 32'(rspValid2), 32'd0);
        cyc();
        chk("t6_post_rspv2", 32'(rspValid2), 32'd1);
        chk("t6_post_rspd2", rspData2, 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
